// File: rtl/gate_bist_ctrl.sv
// LFSR-driven BIST controller for combinational gate-level netlists: applies
// pseudo-random vectors, waits a settle window, and compacts responses in a MISR.
module gate_bist_ctrl #(
    parameter int unsigned          IN_W      = 11,
    parameter int unsigned          OUT_W     = 10,
    parameter int unsigned          CNT_W     = 16,
    parameter int unsigned          SETTLE    = 0,
    parameter logic [IN_W-1:0]      LFSR_TAPS = 11'h500,
    parameter logic [OUT_W-1:0]     MISR_TAPS = 10'h240,
    parameter logic [IN_W-1:0]      LFSR_SEED = 11'h001,
    parameter logic [OUT_W-1:0]     MISR_INIT = 10'h000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [OUT_W-1:0] golden,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [CNT_W-1:0] pattern_cnt
);

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [IN_W-1:0] SEED        = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
    localparam logic [7:0]      SETTLE_LAST = 8'((SETTLE == 0) ? 0 : SETTLE - 1);
    localparam bit              NO_SETTLE   = (SETTLE == 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t           state, state_n;
    logic [IN_W-1:0]  lfsr, lfsr_n;
    logic [OUT_W-1:0] misr, misr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] n_last, n_last_n;
    logic [OUT_W-1:0] gold, gold_n;
    logic [7:0]       wait_cnt, wait_cnt_n;
    logic             pass_q, pass_n;
    logic             sig_match;

    assign sig_match = (misr == gold);

    always_comb begin
        state_n    = state;
        lfsr_n     = lfsr;
        misr_n     = misr;
        cnt_n      = cnt;
        n_last_n   = n_last;
        gold_n     = gold;
        wait_cnt_n = wait_cnt;
        pass_n     = pass_q;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    gold_n = golden;
                    misr_n = MISR_INIT;
                    if (num_patterns != '0) begin
                        lfsr_n     = SEED;
                        cnt_n      = '0;
                        wait_cnt_n = '0;
                        // Store N-1 so the terminal compare needs no subtractor per cycle.
                        n_last_n   = num_patterns - CNT_W'(1);
                        pass_n     = 1'b0;
                        state_n    = NO_SETTLE ? ST_CAPTURE : ST_SETTLE;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    wait_cnt_n = '0;
                    state_n    = ST_IDLE;
                end else if (wait_cnt == SETTLE_LAST) begin
                    wait_cnt_n = '0;
                    state_n    = ST_CAPTURE;
                end else begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else begin
                    misr_n = {misr[OUT_W-2:0], ^(misr & MISR_TAPS)} ^ dut_out;
                    lfsr_n = {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)};
                    cnt_n  = cnt + CNT_W'(1);
                    if (cnt == n_last) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = NO_SETTLE ? ST_CAPTURE : ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                pass_n  = sig_match;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            lfsr     <= SEED;
            misr     <= MISR_INIT;
            cnt      <= '0;
            n_last   <= '0;
            gold     <= '0;
            wait_cnt <= '0;
            pass_q   <= 1'b0;
        end else begin
            state    <= state_n;
            lfsr     <= lfsr_n;
            misr     <= misr_n;
            cnt      <= cnt_n;
            n_last   <= n_last_n;
            gold     <= gold_n;
            wait_cnt <= wait_cnt_n;
            pass_q   <= pass_n;
        end
    end

    // pass is live during the done pulse, then held in pass_q until the next run.
    assign pass        = (state == ST_DONE) ? sig_match : pass_q;
    assign done        = (state == ST_DONE);
    assign busy        = (state == ST_SETTLE) || (state == ST_CAPTURE);
    assign dut_in      = lfsr;
    assign signature   = misr;
    assign pattern_cnt = cnt;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: a SETTLE=0 instance driven from a vector
// table plus hand sequences, and a SETTLE=2 instance for settle-window timing.
module tb_gate_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_start, a_abort, b_start, b_abort;
    logic [15:0] a_n, b_n;
    logic [9:0]  a_gold, b_gold, a_dout, b_dout;
    logic [10:0] a_din, b_din;
    logic        a_busy, a_done, a_pass, b_busy, b_done, b_pass;
    logic [9:0]  a_sig, b_sig;
    logic [15:0] a_cnt, b_cnt;

    gate_bist_ctrl #(.SETTLE(0)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .num_patterns(a_n), .golden(a_gold), .dut_in(a_din), .dut_out(a_dout),
        .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig),
        .pattern_cnt(a_cnt)
    );

    gate_bist_ctrl #(.SETTLE(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .num_patterns(b_n), .golden(b_gold), .dut_in(b_din), .dut_out(b_dout),
        .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig),
        .pattern_cnt(b_cnt)
    );

    typedef struct {
        logic        start, abort;
        logic [15:0] n;
        logic [9:0]  gold, dout;
        logic        busy, done, pass;
        logic [10:0] din;
        logic [9:0]  sig;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    int vectors     = 0;
    int miscompares = 0;

    function automatic vec_t mk(logic s, logic a, logic [15:0] n, logic [9:0] g,
                                logic [9:0] d, logic eb, logic ed, logic ep,
                                logic [10:0] edin, logic [9:0] esig, logic [15:0] ecnt);
        vec_t v;
        v.start = s;   v.abort = a;   v.n = n;     v.gold = g;  v.dout = d;
        v.busy  = eb;  v.done  = ed;  v.pass = ep; v.din = edin;
        v.sig   = esig; v.cnt = ecnt;
        return v;
    endfunction

    task automatic check(input string nm,
                         input logic ab, input logic ad, input logic ap,
                         input logic [10:0] adin, input logic [9:0] asig, input logic [15:0] acnt,
                         input logic eb, input logic ed, input logic ep,
                         input logic [10:0] edin, input logic [9:0] esig, input logic [15:0] ecnt);
        vectors++;
        if ({ab, ad, ap, adin, asig, acnt} !== {eb, ed, ep, edin, esig, ecnt}) begin
            miscompares++;
            $display("FAIL %s: got busy=%0b done=%0b pass=%0b dut_in=%03h sig=%03h cnt=%0d; want busy=%0b done=%0b pass=%0b dut_in=%03h sig=%03h cnt=%0d",
                     nm, ab, ad, ap, adin, asig, acnt, eb, ed, ep, edin, esig, ecnt);
        end
    endtask

    task automatic chk_a(input string nm, input logic eb, input logic ed, input logic ep,
                         input logic [10:0] edin, input logic [9:0] esig, input logic [15:0] ecnt);
        check(nm, a_busy, a_done, a_pass, a_din, a_sig, a_cnt, eb, ed, ep, edin, esig, ecnt);
    endtask

    task automatic chk_b(input string nm, input logic eb, input logic ed, input logic ep,
                         input logic [10:0] edin, input logic [9:0] esig, input logic [15:0] ecnt);
        check(nm, b_busy, b_done, b_pass, b_din, b_sig, b_cnt, eb, ed, ep, edin, esig, ecnt);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected LFSR / MISR (dut_out=1) contents after k captures, worked by hand.
    logic [10:0] din_e [13];
    logic [9:0]  sig_e [13];
    // SETTLE=2, N=2, dut_out=0x005 run: expected state on cycles 1..8 after start.
    logic        bb_e [8];
    logic        bd_e [8];
    logic        bp_e [8];
    logic [10:0] bdin_e [8];
    logic [9:0]  bsig_e [8];
    logic [15:0] bcnt_e [8];

    initial begin
        //                start abort  n      gold    dout  | busy done pass din     sig     cnt
        tbl[0]  = mk(1'b0, 1'b0, 16'd0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 11'h001, 10'h000, 16'd0);
        tbl[1]  = mk(1'b1, 1'b0, 16'd3, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 11'h001, 10'h000, 16'd0);
        tbl[2]  = mk(1'b1, 1'b0, 16'd7, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 11'h002, 10'h000, 16'd1);
        tbl[3]  = mk(1'b0, 1'b0, 16'd7, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 11'h004, 10'h000, 16'd2);
        tbl[4]  = mk(1'b0, 1'b0, 16'd7, 10'h000, 10'h000, 1'b0, 1'b1, 1'b1, 11'h008, 10'h000, 16'd3);
        tbl[5]  = mk(1'b1, 1'b0, 16'd2, 10'h003, 10'h000, 1'b0, 1'b0, 1'b1, 11'h008, 10'h000, 16'd3);
        tbl[6]  = mk(1'b1, 1'b0, 16'd2, 10'h003, 10'h001, 1'b1, 1'b0, 1'b0, 11'h001, 10'h000, 16'd0);
        tbl[7]  = mk(1'b0, 1'b0, 16'd2, 10'h003, 10'h001, 1'b1, 1'b0, 1'b0, 11'h002, 10'h001, 16'd1);
        tbl[8]  = mk(1'b0, 1'b0, 16'd2, 10'h003, 10'h001, 1'b0, 1'b1, 1'b1, 11'h004, 10'h003, 16'd2);
        tbl[9]  = mk(1'b0, 1'b0, 16'd2, 10'h003, 10'h001, 1'b0, 1'b0, 1'b1, 11'h004, 10'h003, 16'd2);
        tbl[10] = mk(1'b1, 1'b0, 16'd2, 10'h002, 10'h001, 1'b1, 1'b0, 1'b0, 11'h001, 10'h000, 16'd0);
        tbl[11] = mk(1'b0, 1'b0, 16'd2, 10'h003, 10'h001, 1'b1, 1'b0, 1'b0, 11'h002, 10'h001, 16'd1);
        tbl[12] = mk(1'b0, 1'b0, 16'd2, 10'h003, 10'h001, 1'b0, 1'b1, 1'b0, 11'h004, 10'h003, 16'd2);
        tbl[13] = mk(1'b0, 1'b0, 16'd2, 10'h003, 10'h001, 1'b0, 1'b0, 1'b0, 11'h004, 10'h003, 16'd2);
        tbl[14] = mk(1'b1, 1'b0, 16'd0, 10'h000, 10'h001, 1'b0, 1'b1, 1'b1, 11'h004, 10'h000, 16'd2);
        tbl[15] = mk(1'b0, 1'b0, 16'd0, 10'h000, 10'h001, 1'b0, 1'b0, 1'b1, 11'h004, 10'h000, 16'd2);
        tbl[16] = mk(1'b1, 1'b0, 16'd5, 10'h000, 10'h001, 1'b1, 1'b0, 1'b0, 11'h001, 10'h000, 16'd0);
        tbl[17] = mk(1'b0, 1'b0, 16'd5, 10'h000, 10'h001, 1'b1, 1'b0, 1'b0, 11'h002, 10'h001, 16'd1);
        tbl[18] = mk(1'b0, 1'b1, 16'd5, 10'h000, 10'h001, 1'b0, 1'b0, 1'b0, 11'h002, 10'h001, 16'd1);
        tbl[19] = mk(1'b0, 1'b0, 16'd5, 10'h000, 10'h001, 1'b0, 1'b0, 1'b0, 11'h002, 10'h001, 16'd1);
        tbl[20] = mk(1'b1, 1'b1, 16'd5, 10'h000, 10'h001, 1'b0, 1'b0, 1'b0, 11'h002, 10'h001, 16'd1);
        tbl[21] = mk(1'b0, 1'b1, 16'd5, 10'h000, 10'h001, 1'b0, 1'b0, 1'b0, 11'h002, 10'h001, 16'd1);

        din_e = '{11'h001, 11'h002, 11'h004, 11'h008, 11'h010, 11'h020, 11'h040,
                  11'h080, 11'h100, 11'h201, 11'h402, 11'h005, 11'h00A};
        sig_e = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F, 10'h03F,
                  10'h07F, 10'h0FE, 10'h1FC, 10'h3F8, 10'h3F1, 10'h3E3};

        bb_e   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bd_e   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bp_e   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bdin_e = '{11'h001, 11'h001, 11'h001, 11'h002, 11'h002, 11'h002, 11'h004, 11'h004};
        bsig_e = '{10'h000, 10'h000, 10'h000, 10'h005, 10'h005, 10'h005, 10'h00F, 10'h00F};
        bcnt_e = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2};

        rst = 1'b1;
        a_start = 1'b0; a_abort = 1'b0; a_n = '0; a_gold = '0; a_dout = '0;
        b_start = 1'b0; b_abort = 1'b0; b_n = '0; b_gold = '0; b_dout = '0;
        tick;
        tick;
        chk_a("reset_a", 1'b0, 1'b0, 1'b0, 11'h001, 10'h000, 16'd0);
        chk_b("reset_b", 1'b0, 1'b0, 1'b0, 11'h001, 10'h000, 16'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            a_start = tbl[i].start;
            a_abort = tbl[i].abort;
            a_n     = tbl[i].n;
            a_gold  = tbl[i].gold;
            a_dout  = tbl[i].dout;
            tick;
            chk_a($sformatf("vec%0d", i), tbl[i].busy, tbl[i].done, tbl[i].pass,
                  tbl[i].din, tbl[i].sig, tbl[i].cnt);
        end
        a_start = 1'b0;
        a_abort = 1'b0;

        // Long run through LFSR and MISR feedback taps.
        a_n = 16'd12; a_gold = 10'h3E3; a_dout = 10'h001; a_start = 1'b1;
        tick;
        a_start = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) tick;
            chk_a($sformatf("long_k%0d", k), (k < 12), (k == 12), (k == 12),
                  din_e[k], sig_e[k], 16'(k));
        end
        tick;
        chk_a("long_hold", 1'b0, 1'b0, 1'b1, 11'h00A, 10'h3E3, 16'd12);

        // Synchronous reset in the middle of a run.
        a_n = 16'd5; a_gold = 10'h000; a_dout = 10'h001; a_start = 1'b1;
        tick;
        a_start = 1'b0;
        tick;
        chk_a("pre_rst", 1'b1, 1'b0, 1'b0, 11'h002, 10'h001, 16'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_a("mid_rst", 1'b0, 1'b0, 1'b0, 11'h001, 10'h000, 16'd0);
        tick;
        chk_a("post_rst", 1'b0, 1'b0, 1'b0, 11'h001, 10'h000, 16'd0);

        // SETTLE=2 instance: busy window, capture cycles and held stimulus.
        b_n = 16'd2; b_gold = 10'h00F; b_dout = 10'h005; b_start = 1'b1;
        tick;
        b_start = 1'b0;
        b_gold  = 10'h3FF;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick;
            chk_b($sformatf("settle_c%0d", c + 1), bb_e[c], bd_e[c], bp_e[c],
                  bdin_e[c], bsig_e[c], bcnt_e[c]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
